// File: rtl/rx_port_arbiter_if.sv
// Bus bundle for rx_port_arbiter: per-port header/stream inputs (s_*) and the
// single forwarded header/stream output (m_*).
// modport master : the arbiter's view (drives s_*_ready and all m_* outputs)
// modport slave  : the surrounding environment's view (decoders + lookup engine)
interface rx_port_arbiter_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned HDR_W     = 449
);
    localparam int unsigned PORT_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS*HDR_W-1:0] s_hdr_data;
    logic [NUM_PORTS-1:0]       s_hdr_valid;
    logic [NUM_PORTS-1:0]       s_hdr_ready;
    logic [NUM_PORTS*32-1:0]    s_axis_tdata;
    logic [NUM_PORTS*4-1:0]     s_axis_tkeep;
    logic [NUM_PORTS-1:0]       s_axis_tlast;
    logic [NUM_PORTS-1:0]       s_axis_tvalid;
    logic [NUM_PORTS-1:0]       s_axis_tready;
    logic [HDR_W-1:0]           m_hdr_data;
    logic [PORT_W-1:0]          m_hdr_port;
    logic                       m_hdr_valid;
    logic                       m_hdr_ready;
    logic [31:0]                m_axis_tdata;
    logic [3:0]                 m_axis_tkeep;
    logic                       m_axis_tlast;
    logic                       m_axis_tvalid;
    logic                       m_axis_tready;

    modport master (
        input  s_hdr_data, s_hdr_valid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        output s_hdr_ready, s_axis_tready,
        output m_hdr_data, m_hdr_port, m_hdr_valid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        input  m_hdr_ready, m_axis_tready
    );

    modport slave (
        output s_hdr_data, s_hdr_valid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        input  s_hdr_ready, s_axis_tready,
        input  m_hdr_data, m_hdr_port, m_hdr_valid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        output m_hdr_ready, m_axis_tready
    );
endinterface

// File: rtl/rx_port_arbiter.sv
// Round-robin scheduler sharing one forwarding path between NUM_PORTS decoders.
// A granted port first hands over its parsed header, then its packet stream up
// to tlast, then the arbiter returns to IDLE and re-arbitrates.
// Optional feature: define ARB_STATS_EN to add per-port completed-packet
// counters on output pkt_count.
module rx_port_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned HDR_W     = 449
) (
    input  logic                    aclk,
    input  logic                    areset,
    rx_port_arbiter_if.master       bus
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0] pkt_count
`endif
);
    localparam int unsigned PORT_W = $clog2(NUM_PORTS);
    localparam int unsigned SUM_W  = PORT_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PORT_W-1:0] grant_q, grant_d;
    logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [PORT_W-1:0] pick;
    logic              pick_found;
    logic [SUM_W-1:0]  scan_sum;
    logic [PORT_W-1:0] grant_inc;
    logic              beat_done;

    logic [HDR_W-1:0]  hdr_arr   [NUM_PORTS];
    logic [31:0]       tdata_arr [NUM_PORTS];
    logic [3:0]        tkeep_arr [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign hdr_arr[g]   = bus.s_hdr_data[g*HDR_W +: HDR_W];
        assign tdata_arr[g] = bus.s_axis_tdata[g*32 +: 32];
        assign tkeep_arr[g] = bus.s_axis_tkeep[g*4 +: 4];
    end

    // First requesting port at or after rr_ptr, wrapping modulo NUM_PORTS
    always_comb begin
        pick       = rr_ptr_q;
        pick_found = 1'b0;
        scan_sum   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + SUM_W'(i);
            if (scan_sum >= SUM_W'(NUM_PORTS)) begin
                scan_sum = scan_sum - SUM_W'(NUM_PORTS);
            end
            if (!pick_found && bus.s_hdr_valid[scan_sum[PORT_W-1:0]]) begin
                pick_found = 1'b1;
                pick       = scan_sum[PORT_W-1:0];
            end
        end
    end

    assign grant_inc = (grant_q == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
    assign beat_done = (state_q == DATA) && bus.s_axis_tvalid[grant_q] &&
                       bus.m_axis_tready && bus.s_axis_tlast[grant_q];

    // Next-state logic and all handshake outputs, decoded from the registered grant
    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        rr_ptr_d          = rr_ptr_q;
        bus.s_hdr_ready   = '0;
        bus.s_axis_tready = '0;
        bus.m_hdr_valid   = 1'b0;
        bus.m_hdr_data    = hdr_arr[grant_q];
        bus.m_hdr_port    = grant_q;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tdata  = tdata_arr[grant_q];
        bus.m_axis_tkeep  = tkeep_arr[grant_q];
        bus.m_axis_tlast  = bus.s_axis_tlast[grant_q];
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick;
                    state_d = HDR;
                end
            end
            HDR: begin
                bus.m_hdr_valid          = 1'b1;
                bus.s_hdr_ready[grant_q] = bus.m_hdr_ready;
                if (bus.m_hdr_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                bus.m_axis_tvalid          = bus.s_axis_tvalid[grant_q];
                bus.s_axis_tready[grant_q] = bus.m_axis_tready;
                if (beat_done) begin
                    rr_ptr_d = grant_inc;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] pkt_count_q [NUM_PORTS];
    logic [31:0] pkt_count_d [NUM_PORTS];

    // Count completed packets of the granted port; 32-bit wrap is intentional
    always_comb begin
        pkt_count_d = pkt_count_q;
        if (beat_done) begin
            pkt_count_d[grant_q] = pkt_count_q[grant_q] + 32'd1;
        end
    end

    // Packet counter registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pkt_count_q <= '{default: '0};
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
        assign pkt_count[g*32 +: 32] = pkt_count_q[g];
    end
`endif
endmodule

// File: tb/tb_rx_port_arbiter.sv
// Self-checking bench for rx_port_arbiter: per-port packet sources with
// randomized valid gaps and sink readies, checked every cycle against a
// transaction-level round-robin model.
module tb_rx_port_arbiter;
    localparam int unsigned NP = 4;
    localparam int unsigned HW = 449;

    logic aclk;
    logic areset;

    rx_port_arbiter_if #(.NUM_PORTS(NP), .HDR_W(HW)) bus ();

`ifdef ARB_STATS_EN
    logic [NP*32-1:0] pkt_count;
    rx_port_arbiter #(.NUM_PORTS(NP), .HDR_W(HW)) dut (
        .aclk(aclk), .areset(areset), .bus(bus), .pkt_count(pkt_count)
    );
`else
    rx_port_arbiter #(.NUM_PORTS(NP), .HDR_W(HW)) dut (
        .aclk(aclk), .areset(areset), .bus(bus)
    );
`endif

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // packet sources
    logic [HW-1:0] hdr_q [NP][$];
    int unsigned   len_q [NP][$];
    int unsigned   seq_q [NP][$];
    int unsigned   src_phase [NP];   // 0: offering header, 1: streaming beats
    int unsigned   src_beat  [NP];
    bit            src_tv    [NP];
    int unsigned   seq_ctr = 0;

    // reference model: who is being served and in which phase
    int unsigned mdl_phase;          // 0: idle, 1: header offered, 2: streaming
    int unsigned mdl_port;
    int unsigned mdl_rr;
    int unsigned obs_log [$];

    int unsigned hr_pct = 100;
    int unsigned tr_pct = 100;
    bit          tr_toggle = 1'b0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] beat_data(input int unsigned p, input int unsigned seq, input int unsigned b);
        return {4'(p), 12'(seq), 16'(b)};
    endfunction

    function automatic logic [3:0] beat_keep(input int unsigned p, input int unsigned b);
        return 4'((b + p) % 15 + 1);
    endfunction

    function automatic int unsigned rr_pick(input int unsigned rr, input logic [NP-1:0] req);
        for (int unsigned k = 0; k < NP; k++) begin
            if (req[(rr + k) % NP]) return (rr + k) % NP;
        end
        return 0;
    endfunction

    task automatic add_pkt(input int unsigned p, input int unsigned len);
        logic [479:0] tmp;
        for (int unsigned w = 0; w < 15; w++) tmp[w*32 +: 32] = $urandom;
        tmp[15:0] = {4'(p), 12'(seq_ctr)};
        hdr_q[p].push_back(tmp[HW-1:0]);
        len_q[p].push_back(len);
        seq_q[p].push_back(seq_ctr);
        seq_ctr = seq_ctr + 1;
    endtask

    task automatic drive();
        for (int unsigned p = 0; p < NP; p++) begin
            bus.s_hdr_valid[p] = (src_phase[p] == 0) && (hdr_q[p].size() > 0);
            bus.s_hdr_data[p*HW +: HW] = (hdr_q[p].size() > 0) ? hdr_q[p][0] : '0;
            if (src_phase[p] == 1) begin
                bus.s_axis_tvalid[p]       = src_tv[p];
                bus.s_axis_tdata[p*32 +: 32] = beat_data(p, seq_q[p][0], src_beat[p]);
                bus.s_axis_tkeep[p*4 +: 4]   = beat_keep(p, src_beat[p]);
                bus.s_axis_tlast[p]        = (src_beat[p] == len_q[p][0] - 1);
            end else begin
                bus.s_axis_tvalid[p]       = 1'b0;
                bus.s_axis_tdata[p*32 +: 32] = $urandom;
                bus.s_axis_tkeep[p*4 +: 4]   = 4'($urandom);
                bus.s_axis_tlast[p]        = 1'($urandom);
            end
        end
    endtask

    task automatic clear_env();
        for (int unsigned p = 0; p < NP; p++) begin
            hdr_q[p].delete();
            len_q[p].delete();
            seq_q[p].delete();
            src_phase[p] = 0;
            src_beat[p]  = 0;
            src_tv[p]    = 1'b0;
        end
        mdl_phase = 0;
        mdl_port  = 0;
        mdl_rr    = 0;
        bus.m_hdr_ready   = 1'b0;
        bus.m_axis_tready = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        clear_env();
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    // one clock: check outputs at negedge, advance model, update stimulus after posedge
    task automatic cycle();
        logic [NP-1:0] exp_hr, exp_tr;
        bit exp_tv, hdr_hs, dat_hs, last;
        @(negedge aclk);
        exp_hr = '0;
        exp_tr = '0;
        exp_tv = (mdl_phase == 2) && (src_phase[mdl_port] == 1) && src_tv[mdl_port];
        if (mdl_phase == 1 && bus.m_hdr_ready)   exp_hr[mdl_port] = 1'b1;
        if (mdl_phase == 2 && bus.m_axis_tready) exp_tr[mdl_port] = 1'b1;
        chk("m_hdr_valid", bus.m_hdr_valid, mdl_phase == 1);
        chk("m_axis_tvalid", bus.m_axis_tvalid, exp_tv);
        chk("s_hdr_ready", bus.s_hdr_ready, exp_hr);
        chk("s_axis_tready", bus.s_axis_tready, exp_tr);
        if (mdl_phase == 1) begin
            chk("m_hdr_port", bus.m_hdr_port, mdl_port);
            chk("m_hdr_data", bus.m_hdr_data, hdr_q[mdl_port][0]);
        end
        if (exp_tv) begin
            chk("m_axis_tdata", bus.m_axis_tdata, beat_data(mdl_port, seq_q[mdl_port][0], src_beat[mdl_port]));
            chk("m_axis_tkeep", bus.m_axis_tkeep, beat_keep(mdl_port, src_beat[mdl_port]));
            chk("m_axis_tlast", bus.m_axis_tlast, src_beat[mdl_port] == len_q[mdl_port][0] - 1);
        end
        hdr_hs = (mdl_phase == 1) && bus.m_hdr_ready;
        dat_hs = exp_tv && bus.m_axis_tready;
        last   = dat_hs && (src_beat[mdl_port] == len_q[mdl_port][0] - 1);
        if (hdr_hs) obs_log.push_back(int'(bus.m_hdr_port));
        case (mdl_phase)
            0: if (bus.s_hdr_valid != '0) begin
                   mdl_port  = rr_pick(mdl_rr, bus.s_hdr_valid);
                   mdl_phase = 1;
               end
            1: if (hdr_hs) mdl_phase = 2;
            default: if (last) begin
                   mdl_rr    = (mdl_port + 1) % NP;
                   mdl_phase = 0;
               end
        endcase
        @(posedge aclk);
        #1;
        if (hdr_hs) begin
            src_phase[mdl_port] = 1;
            src_beat[mdl_port]  = 0;
            src_tv[mdl_port]    = ($urandom_range(3) != 0);
        end else if (dat_hs) begin
            if (last) begin
                void'(hdr_q[mdl_port].pop_front());
                void'(len_q[mdl_port].pop_front());
                void'(seq_q[mdl_port].pop_front());
                src_phase[mdl_port] = 0;
                src_tv[mdl_port]    = 1'b0;
            end else begin
                src_beat[mdl_port] = src_beat[mdl_port] + 1;
                src_tv[mdl_port]   = ($urandom_range(3) != 0);
            end
        end
        for (int unsigned p = 0; p < NP; p++) begin
            if (src_phase[p] == 1 && !src_tv[p]) src_tv[p] = ($urandom_range(3) != 0);
        end
        bus.m_hdr_ready   = ($urandom_range(99) < hr_pct);
        bus.m_axis_tready = tr_toggle ? ~bus.m_axis_tready : ($urandom_range(99) < tr_pct);
        drive();
    endtask

    task automatic run_drain(input int unsigned budget);
        int unsigned n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            cycle();
            n = n + 1;
            busy = (mdl_phase != 0);
            for (int unsigned p = 0; p < NP; p++) if (hdr_q[p].size() > 0) busy = 1'b1;
        end
        chk("drain_within_budget", busy, 1'b0);
    endtask

    initial begin
        do_reset();
        // reset state
        chk("rst_m_hdr_valid", bus.m_hdr_valid, 1'b0);
        chk("rst_m_axis_tvalid", bus.m_axis_tvalid, 1'b0);
        chk("rst_s_hdr_ready", bus.s_hdr_ready, '0);
        chk("rst_s_axis_tready", bus.s_axis_tready, '0);
        chk("rst_m_hdr_port", bus.m_hdr_port, '0);
        repeat (3) cycle();

        // single port: port 2, 3-beat packet, sink always ready
        obs_log.delete();
        add_pkt(2, 3);
        run_drain(50);
        chk("t2_grants", obs_log.size(), 1);
        chk("t2_port", obs_log[0], 2);

        // round-robin over held requests from ports 0,1,3
        do_reset();
        obs_log.delete();
        for (int unsigned r = 0; r < 2; r++) begin
            add_pkt(0, 1 + $urandom_range(2));
            add_pkt(1, 1 + $urandom_range(2));
            add_pkt(3, 1 + $urandom_range(2));
        end
        run_drain(200);
        chk("t3_grants", obs_log.size(), 6);
        for (int unsigned k = 0; k < 6 && k < obs_log.size(); k++) begin
            logic [1:0] order [3];
            order = '{2'd0, 2'd1, 2'd3};
            chk("t3_order", obs_log[k], order[k % 3]);
        end

        // header back-pressure, then toggling stream ready
        hr_pct = 0;
        bus.m_hdr_ready = 1'b0;
        add_pkt(1, 6);
        repeat (6) cycle();
        hr_pct = 100;
        tr_toggle = 1'b1;
        run_drain(100);
        tr_toggle = 1'b0;

        // wrap: single-beat on the last port, then ports 0 and 3 together
        add_pkt(NP - 1, 1);
        run_drain(30);
        obs_log.delete();
        add_pkt(0, 2);
        add_pkt(3, 2);
        run_drain(60);
        chk("t5_first_grant", obs_log[0], 0);
        chk("t5_second_grant", obs_log[1], 3);

        // random traffic with random sink readiness
        hr_pct = 70;
        tr_pct = 70;
        for (int unsigned c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) add_pkt($urandom_range(NP - 1), 1 + $urandom_range(4));
            cycle();
        end
        run_drain(3000);

        // async reset mid-packet
        hr_pct = 100;
        tr_pct = 100;
        add_pkt(1, 2);
        run_drain(30);
        add_pkt(2, 8);
        for (int unsigned c = 0; c < 40 && !(mdl_phase == 2 && src_beat[2] >= 2); c++) cycle();
        chk("t1_mid_data_reached", (mdl_phase == 2) && (src_beat[2] >= 2), 1'b1);
        #2;
        areset = 1'b1;
        #1;
        chk("t1_m_hdr_valid", bus.m_hdr_valid, 1'b0);
        chk("t1_m_axis_tvalid", bus.m_axis_tvalid, 1'b0);
        chk("t1_s_hdr_ready", bus.s_hdr_ready, '0);
        chk("t1_s_axis_tready", bus.s_axis_tready, '0);
        clear_env();
        @(posedge aclk);
        #1;
        areset = 1'b0;
        obs_log.delete();
        for (int unsigned p = 0; p < NP; p++) add_pkt(p, 1);
        run_drain(60);
        chk("t1_rr_after_reset", obs_log[0], 0);

`ifdef ARB_STATS_EN
        // per-port packet counters
        do_reset();
        for (int unsigned k = 0; k < 4; k++) add_pkt(1, 1 + $urandom_range(3));
        for (int unsigned k = 0; k < 2; k++) add_pkt(0, 1 + $urandom_range(3));
        run_drain(200);
        chk("t6_cnt_p0", pkt_count[31:0], 32'd2);
        chk("t6_cnt_p1", pkt_count[63:32], 32'd4);
        chk("t6_cnt_p2", pkt_count[95:64], 32'd0);
        chk("t6_cnt_p3", pkt_count[127:96], 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
